// File: rtl/timer_a_iv_arb.sv
// Timer_A interrupt vector arbiter: priority-encodes CCR1..CCRn and TAIFG
// into TAxIV and pulses the winning source's flag clear on TAxIV access.
module timer_a_iv_arb #(
  parameter logic [15:0] TAnIV_OFFSET = 16'h012E,
  parameter int          NUM_CCR      = 3
) (
  input  logic        MCLK,
  input  logic        wTACLR,
  input  logic [15:0] MAB,
  input  logic        MR,
  input  logic        MW,
  input  logic        BW,
  input  logic [5:0]  CCIFG,
  input  logic [5:0]  CCIE,
  input  logic        TAIFG,
  input  logic        TAIE,
  output logic [15:0] MDBread,
  output logic [5:0]  CCIFGclr,
  output logic        TAIFGclr,
  output logic        IRQ
);

  localparam int NSRC = NUM_CCR - 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLR    = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] iv_q, iv_d;
  logic [6:0]  clr_q, clr_d;

  logic [5:0]  ccr_pend;
  logic [15:0] enc;
  logic [6:0]  clr_src;
  logic        word_hit;
  logic        byte_lo;
  logic        byte_hi;
  logic        acc;
  logic        rd_sel;
  logic [15:0] rd_data;

  // Pending CCR sources; CCRs beyond this timer's count never pend.
  always_comb begin
    ccr_pend = '0;
    for (int k = 0; k < 6; k++) begin
      ccr_pend[k] = (k < NSRC) && CCIFG[k] && CCIE[k];
    end
  end

  // Priority encode: lowest CCR index wins, TAIFG only when no CCR pends.
  always_comb begin
    enc = '0;
    if (TAIFG && TAIE) begin
      enc = 16'h000E;
    end
    for (int k = 5; k >= 0; k--) begin
      if (ccr_pend[k]) begin
        enc = 16'(2 * (k + 1));
      end
    end
  end

  // One-hot clear selector for the source currently latched in IVreg.
  always_comb begin
    clr_src = '0;
    for (int k = 0; k < 6; k++) begin
      if (iv_q == 16'(2 * (k + 1))) begin
        clr_src[k] = 1'b1;
      end
    end
    if (iv_q == 16'h000E) begin
      clr_src[6] = 1'b1;
    end
  end

  // Address decode; the odd byte is readable but never counts as an access.
  always_comb begin
    word_hit = !BW && ((MAB & 16'hFFFE) == TAnIV_OFFSET);
    byte_lo  = BW && (MAB == TAnIV_OFFSET);
    byte_hi  = BW && (MAB == (TAnIV_OFFSET + 16'd1));
    acc      = (MR || MW) && (word_hit || byte_lo);
    rd_sel   = MR && (word_hit || byte_lo || byte_hi);
  end

  // Read mux: vector only visible while idle, zero during a clear sequence.
  always_comb begin
    rd_data = '0;
    if (state_q == IDLE) begin
      if (word_hit) begin
        rd_data = iv_q;
      end else if (byte_lo) begin
        rd_data = {8'h00, iv_q[7:0]};
      end
    end
  end

  assign MDBread = rd_sel ? rd_data : 16'hzzzz;

  // Next-state: IDLE tracks sources, access freezes IVreg for CLR/SETTLE.
  always_comb begin
    state_d = state_q;
    iv_d    = iv_q;
    clr_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (acc && (iv_q != 16'h0000)) begin
          state_d = CLR;
          clr_d   = clr_src;
        end else begin
          iv_d = enc;
        end
      end
      CLR: begin
        state_d = SETTLE;
      end
      SETTLE: begin
        iv_d    = enc;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, vector and clear-pulse registers.
  always_ff @(posedge MCLK or posedge wTACLR) begin
    if (wTACLR) begin
      state_q <= IDLE;
      iv_q    <= '0;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      iv_q    <= iv_d;
      clr_q   <= clr_d;
    end
  end

  assign CCIFGclr = (state_q == CLR) ? clr_q[5:0] : 6'b000000;
  assign TAIFGclr = (state_q == CLR) && clr_q[6];
  assign IRQ      = (iv_q != 16'h0000) && (state_q == IDLE);

endmodule

// File: tb/tb_timer_a_iv_arb.sv
// Self-checking bench for timer_a_iv_arb: directed scenarios plus a
// randomized run against a cycle-level reference model.
module tb_timer_a_iv_arb;

  localparam logic [15:0] OFF     = 16'h012E;
  localparam int          NUM_CCR = 3;

  logic        MCLK = 1'b0;
  logic        wTACLR = 1'b1;
  logic [15:0] MAB = '0;
  logic        MR = 1'b0;
  logic        MW = 1'b0;
  logic        BW = 1'b0;
  logic [5:0]  CCIFG = '0;
  logic [5:0]  CCIE = '0;
  logic        TAIFG = 1'b0;
  logic        TAIE = 1'b0;
  logic [15:0] MDBread;
  logic [5:0]  CCIFGclr;
  logic        TAIFGclr;
  logic        IRQ;

  int n_checks = 0;
  int n_fail = 0;

  logic [15:0] m_iv = '0;
  int          m_busy = 0;
  logic [6:0]  m_clr = '0;
  logic        m_irq = 1'b0;

  timer_a_iv_arb #(
    .TAnIV_OFFSET(OFF),
    .NUM_CCR(NUM_CCR)
  ) dut (
    .MCLK(MCLK),
    .wTACLR(wTACLR),
    .MAB(MAB),
    .MR(MR),
    .MW(MW),
    .BW(BW),
    .CCIFG(CCIFG),
    .CCIE(CCIE),
    .TAIFG(TAIFG),
    .TAIE(TAIE),
    .MDBread(MDBread),
    .CCIFGclr(CCIFGclr),
    .TAIFGclr(TAIFGclr),
    .IRQ(IRQ)
  );

  always #5 MCLK = ~MCLK;

  function automatic logic [15:0] ref_enc();
    for (int n = 1; n < NUM_CCR; n++) begin
      if (CCIFG[n-1] && CCIE[n-1]) return 16'(2 * n);
    end
    if (TAIFG && TAIE) return 16'h000E;
    return 16'h0000;
  endfunction

  function automatic logic [15:0] ref_read();
    logic w, b0, b1;
    w  = !BW && ((MAB & 16'hFFFE) == OFF);
    b0 = BW && (MAB == OFF);
    b1 = BW && (MAB == OFF + 16'd1);
    if (!MR || !(w || b0 || b1)) return 16'hzzzz;
    if (wTACLR || b1 || m_busy != 0) return 16'h0000;
    if (b0) return {8'h00, m_iv[7:0]};
    return m_iv;
  endfunction

  task automatic model_step();
    logic acc;
    acc = (MR || MW) &&
          ((!BW && ((MAB & 16'hFFFE) == OFF)) || (BW && MAB == OFF));
    m_clr = '0;
    if (wTACLR) begin
      m_iv = '0;
      m_busy = 0;
    end else if (m_busy == 0) begin
      if (acc && m_iv != 0) begin
        if (m_iv == 16'h000E) m_clr = 7'h40;
        else m_clr = 7'(1) << (int'(m_iv) / 2 - 1);
        m_busy = 2;
      end else begin
        m_iv = ref_enc();
      end
    end else if (m_busy == 2) begin
      m_busy = 1;
    end else begin
      m_iv = ref_enc();
      m_busy = 0;
    end
    m_irq = (m_iv != 0) && (m_busy == 0) && !wTACLR;
  endtask

  task automatic tick();
    logic [5:0]  cc;
    logic        tc;
    logic [15:0] er;
    #1;
    er = ref_read();
    n_checks++;
    if (MDBread !== er) begin
      n_fail++;
      $display("FAIL read_data: got %h want %h", MDBread, er);
    end
    cc = CCIFGclr;
    tc = TAIFGclr;
    model_step();
    @(posedge MCLK);
    #1;
    CCIFG = CCIFG & ~cc;
    TAIFG = TAIFG & ~tc;
    n_checks++;
    if (IRQ !== m_irq) begin
      n_fail++;
      $display("FAIL irq: got %b want %b", IRQ, m_irq);
    end
    n_checks++;
    if ({TAIFGclr, CCIFGclr} !== m_clr) begin
      n_fail++;
      $display("FAIL clr: got %b want %b", {TAIFGclr, CCIFGclr}, m_clr);
    end
  endtask

  task automatic bus_idle();
    MR = 1'b0;
    MW = 1'b0;
    BW = 1'b0;
    MAB = 16'h0000;
  endtask

  task automatic do_reset();
    bus_idle();
    wTACLR = 1'b1;
    @(posedge MCLK);
    #1;
    wTACLR = 1'b0;
    m_iv = '0;
    m_busy = 0;
    m_clr = '0;
    m_irq = 1'b0;
  endtask

  task automatic chk16(string nm, logic [15:0] got, logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic test_reset();
    CCIFG = 6'b000011;
    CCIE = 6'b000011;
    wTACLR = 1'b1;
    MR = 1'b1;
    MAB = OFF;
    repeat (2) @(posedge MCLK);
    #1;
    chk16("rst_irq", 16'(IRQ), 16'h0);
    chk16("rst_clr", 16'({TAIFGclr, CCIFGclr}), 16'h0);
    chk16("rst_read", MDBread, 16'h0000);
    do_reset();
    CCIFG = '0;
    CCIE = '0;
  endtask

  task automatic test_ccr_priority();
    do_reset();
    CCIFG = 6'b000011;
    CCIE = 6'b000011;
    tick();
    chk16("p_irq", 16'(IRQ), 16'h1);
    MR = 1'b1;
    MAB = OFF;
    #1;
    chk16("p_read", MDBread, 16'h0002);
    tick();
    chk16("p_clr", 16'(CCIFGclr), 16'h01);
    bus_idle();
    tick();
    chk16("p_clr_off", 16'(CCIFGclr), 16'h00);
    tick();
    MR = 1'b1;
    MAB = OFF;
    #1;
    chk16("p_settled", MDBread, 16'h0004);
    bus_idle();
  endtask

  task automatic test_taifg();
    do_reset();
    CCIFG = '0;
    CCIE = '0;
    TAIFG = 1'b1;
    TAIE = 1'b1;
    tick();
    MR = 1'b1;
    BW = 1'b1;
    MAB = OFF;
    #1;
    chk16("ta_read", MDBread, 16'h000E);
    tick();
    chk16("ta_clr", 16'(TAIFGclr), 16'h1);
    bus_idle();
    tick();
    tick();
    chk16("ta_irq", 16'(IRQ), 16'h0);
    chk16("ta_flag", 16'(TAIFG), 16'h0);
    TAIE = 1'b0;
  endtask

  task automatic test_ignored_ccr();
    do_reset();
    CCIFG = 6'b100000;
    CCIE = 6'b100000;
    repeat (3) tick();
    chk16("ign_irq", 16'(IRQ), 16'h0);
    MR = 1'b1;
    MAB = OFF;
    #1;
    chk16("ign_read", MDBread, 16'h0000);
    bus_idle();
    CCIFG = '0;
    CCIE = '0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    CCIFG = 6'b000001;
    CCIE = 6'b000001;
    tick();
    MR = 1'b1;
    BW = 1'b1;
    MAB = OFF + 16'd1;
    #1;
    chk16("hi_read", MDBread, 16'h0000);
    tick();
    chk16("hi_noclr", 16'(CCIFGclr), 16'h00);
    chk16("hi_irq", 16'(IRQ), 16'h1);
    BW = 1'b0;
    MAB = OFF;
    tick();
    chk16("b2b_clr1", 16'(CCIFGclr), 16'h01);
    #1;
    chk16("b2b_read", MDBread, 16'h0000);
    tick();
    chk16("b2b_clr2", 16'(CCIFGclr), 16'h00);
    bus_idle();
    tick();
    tick();
    chk16("b2b_irq", 16'(IRQ), 16'h0);
  endtask

  task automatic test_reset_mid_clr();
    do_reset();
    CCIFG = 6'b000011;
    CCIE = 6'b000011;
    tick();
    MR = 1'b1;
    MAB = OFF;
    tick();
    bus_idle();
    wTACLR = 1'b1;
    #1;
    chk16("rc_clr", 16'(CCIFGclr), 16'h00);
    chk16("rc_irq", 16'(IRQ), 16'h0);
    MR = 1'b1;
    MAB = OFF;
    #1;
    chk16("rc_read", MDBread, 16'h0000);
    bus_idle();
    tick();
    wTACLR = 1'b0;
    tick();
    MR = 1'b1;
    MAB = OFF;
    #1;
    chk16("rc_reenc", MDBread, 16'h0002);
    bus_idle();
  endtask

  task automatic test_write();
    do_reset();
    CCIFG = 6'b000011;
    CCIE = 6'b000011;
    tick();
    MR = 1'b1;
    MAB = OFF;
    tick();
    bus_idle();
    tick();
    tick();
    MR = 1'b1;
    MAB = OFF;
    #1;
    chk16("wr_pre", MDBread, 16'h0004);
    MR = 1'b0;
    MW = 1'b1;
    tick();
    chk16("wr_clr", 16'({TAIFGclr, CCIFGclr}), 16'h02);
    bus_idle();
    tick();
    chk16("wr_clr_off", 16'({TAIFGclr, CCIFGclr}), 16'h00);
    tick();
    chk16("wr_irq", 16'(IRQ), 16'h0);
    chk16("wr_flags", 16'(CCIFG), 16'h00);
  endtask

  task automatic test_random();
    int r;
    do_reset();
    CCIFG = '0;
    CCIE = '0;
    TAIFG = 1'b0;
    TAIE = 1'b0;
    repeat (1500) begin
      if ($urandom_range(0, 7) == 0) CCIFG = CCIFG | 6'($urandom);
      if ($urandom_range(0, 15) == 0) CCIE = 6'($urandom);
      if ($urandom_range(0, 9) == 0) TAIFG = 1'b1;
      if ($urandom_range(0, 15) == 0) TAIE = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 3);
      MR = (r == 1);
      MW = (r == 2);
      BW = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 3);
      if (r <= 1) MAB = OFF;
      else if (r == 2) MAB = OFF + 16'd1;
      else MAB = 16'($urandom);
      wTACLR = ($urandom_range(0, 199) == 0);
      tick();
    end
    wTACLR = 1'b0;
    bus_idle();
  endtask

  initial begin
    test_reset();
    test_ccr_priority();
    test_taifg();
    test_ignored_ccr();
    test_back_to_back();
    test_reset_mid_clr();
    test_write();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_a_iv_arb.md
TIMER_A_IV_ARB -- requirements
Module: timer_a_iv_arb

Interface -- parameters
REQ-001 The block SHALL have parameter TAnIV_OFFSET, default TA0IV, giving the byte address of this timer's TAxIV register.
REQ-002 The block SHALL have parameter NUM_CCR, default 3, legal range 2..7, giving the number of CCRs including CCR0; CCR0 has its own vector and is not arbitrated here.

Interface -- ports
REQ-003 The block SHALL have MCLK, input, 1 bit: system clock; all state is updated on posedge MCLK.
REQ-004 The block SHALL have wTACLR, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have MAB, input, 16 bits: memory address from the CPU.
REQ-006 The block SHALL have MR and MW, inputs, 1 bit each: memory read and memory write strobes.
REQ-007 The block SHALL have BW, input, 1 bit: byte access when 1, word access when 0.
REQ-008 The block SHALL have CCIFG and CCIE, inputs, 6 bits each: bit k is the flag and enable of CCR(k+1); bits k >= NUM_CCR-1 are ignored.
REQ-009 The block SHALL have TAIFG and TAIE, inputs, 1 bit each: overflow flag and enable from the timer base.
REQ-010 The block SHALL have MDBread, output, 16 bits: read data; high-Z when TAxIV is not addressed.
REQ-011 The block SHALL have CCIFGclr, output, 6 bits: one-cycle clear pulses to the CCMs, same bit mapping as CCIFG.
REQ-012 The block SHALL have TAIFGclr, output, 1 bit: one-cycle clear pulse to the timer base.
REQ-013 The block SHALL have IRQ, output, 1 bit: interrupt request to the CPU for the non-CCR0 vector.

Function
REQ-014 A source SHALL be pending when its flag and its enable are both 1.
REQ-015 Priority SHALL be CCR1 highest, ascending CCR index, with TAIFG lowest.
REQ-016 Encoding SHALL be: no source 0x0000; CCRn 2n (0x02..0x0C); TAIFG 0x000E.
REQ-017 The block SHALL hold a registered 16-bit IVreg and a 2-bit FSM with states IDLE, CLR and SETTLE.
REQ-018 In IDLE, IVreg SHALL load the priority encode of the pending sources every MCLK.
REQ-019 An access SHALL be MR or MW with either (BW=0 and (MAB & ~1) = TAnIV_OFFSET) or (BW=1 and MAB = TAnIV_OFFSET).
REQ-020 MDBread SHALL be combinational: word access returns IVreg; byte access at the offset returns {8'h00, IVreg[7:0]}; byte access at offset+1 returns 0x0000 and is not an access under REQ-019.
REQ-021 An access in IDLE with IVreg != 0 SHALL move the FSM to CLR and register the one-hot clear for the IVreg source; IVreg SHALL be held.
REQ-022 In CLR, exactly one clear output SHALL be high for exactly one cycle, IVreg SHALL be held, and the next state SHALL be SETTLE.
REQ-023 In SETTLE, all clear outputs SHALL be low and IVreg SHALL load the fresh priority encode, by which time the source flag has cleared; the next state SHALL be IDLE.
REQ-024 An access in IDLE with IVreg = 0 SHALL produce no clear and no state change.
REQ-025 A read during CLR or SETTLE SHALL return 0x0000 and SHALL generate no clear.
REQ-026 Write data SHALL be ignored; a write access SHALL behave exactly as a read access for clearing.
REQ-027 IRQ SHALL equal (IVreg != 0) AND (state = IDLE).
REQ-028 A flag that rises while the FSM is in CLR or SETTLE SHALL NOT be lost; it is picked up by the SETTLE or IDLE encode.
REQ-029 A source whose enable drops while it is held in IVreg SHALL still be cleared if accessed in IDLE; IVreg SHALL re-encode in the next IDLE cycle.

Reset
REQ-030 While wTACLR is high, IVreg SHALL be 0, the state SHALL be IDLE, CCIFGclr SHALL be 0, TAIFGclr SHALL be 0 and IRQ SHALL be 0, asynchronously.
REQ-031 Reset asserted in CLR SHALL abort the clear pulse immediately.
REQ-032 After wTACLR deasserts, the first posedge SHALL perform a normal IDLE encode.

Verification
REQ-033 CCIFG=6'b000011, CCIE=6'b000011, NUM_CCR=3; after 1 clk: IVreg=0x0002 and IRQ=1; word read of TA0IV returns 0x0002; CCIFGclr=6'b000001 for 1 cycle; after SETTLE: IVreg=0x0004.
REQ-034 Only TAIFG=TAIE=1; byte read at TA0IV returns 0x000E; TAIFGclr pulses once; after the pulse the flag drops and IVreg=0, IRQ=0.
REQ-035 CCIFG[5]=1, CCIE[5]=1, NUM_CCR=3: IVreg stays 0 and IRQ stays 0.
REQ-036 Read at offset+1 with BW=1 returns 0x0000 and produces no clear; a back-to-back second read during CLR returns 0x0000 and produces no second clear.
REQ-037 wTACLR asserted mid-CLR: clear outputs drop the same cycle and IVreg=0; after release IVreg re-encodes the still-set flags.
REQ-038 MW to TA0IV with MDBwrite=0xFFFF while IVreg=0x0004 produces CCIFGclr=6'b000010 for one cycle and no other side effect.
